seg_scan_reader: RTL and testbench
==================================

Name: seg_scan_reader

Overview:
- Reads back a multiplexed, scanned 7-segment display bus and recovers the BCD digit shown on each position.
- Debounces each digit pattern over consecutive samples, assembles a full frame of NUM_DIGITS digits, and presents it with a valid/ready handshake.
- Used as a display-readback and self-check monitor on the display output path.

Parameters:
- NUM_DIGITS, 4, number of scanned digit positions (1..8).
- STABLE_CNT, 3, consecutive identical samples required before a digit is committed (2..15).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sample_en  input  1  sample strobe; inputs are evaluated only on clk edges where sample_en=1.
- seg_in  input  7  segment lines, active high, seg_in[6:0]=abcdefg.
- dig_en  input  NUM_DIGITS  digit enable, active high, one-hot; bit i selects position i.
- bcd_out  output  4*NUM_DIGITS  frame digits; digit i is bcd_out[4i+3:4i].
- digit_err  output  NUM_DIGITS  per-digit flag: committed pattern was not a legal glyph.
- frame_valid  output  1  frame available.
- frame_ready  input  1  consumer accepts the frame.

Behaviour:
- Reset (async assert, sync release):
  - bcd_out=0, digit_err=0, frame_valid=0.
  - State=COLLECT, captured mask=0, stability counter=0, previous-sample regs=0.
- Decode table (abcdefg -> bcd):
  - 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9.
  - 00 (blank) -> 4'hF with err=0.
  - Any other pattern -> 4'hF with err=1.
- Stability:
  - Per sampled cycle, if dig_en is one-hot and {dig_en,seg_in} equals the previous sample, the counter increments, saturating at STABLE_CNT.
  - Otherwise the counter loads 1.
  - If dig_en is zero or multi-hot: counter loads 0, no commit, previous sample still updated.
- Commit:
  - On the edge where the counter transitions to STABLE_CNT, write the decoded value and err into slot i (shadow regs) and set captured[i].
  - A repeat commit of the same slot overwrites it (latest wins).
  - Latency: a stable pattern commits on the STABLE_CNT-th consecutive sampled edge.
- FSM:
  - COLLECT:
    - When captured is all-ones (registered), on the next edge copy shadow slots to bcd_out/digit_err, set frame_valid=1, clear captured, and go to HOLD.
    - A commit in that same edge lands in the cleared mask (captured[i]=1 after the clear).
  - HOLD:
    - bcd_out, digit_err and frame_valid are held stable.
    - Sampling and commits continue into the shadow slots.
    - On frame_valid && frame_ready: frame_valid=0 on the next edge, go to COLLECT.
    - If captured is already all-ones at return, the next frame issues one cycle later.
- frame_ready is ignored while frame_valid=0.
- Reset mid-frame discards all partial captures and any pending frame.
- sample_en=0 freezes the counter, previous-sample regs and shadow slots; the FSM and handshake still run.

Optional Feature:
- SEG_ACTIVE_LOW_EN:
  - Defined: seg_in and dig_en are bitwise inverted at the input, before any logic (common-anode displays). Blank = all lines high.
  - Undefined: inputs are used as-is (active high).
  - Decode table, outputs and timing are identical in both builds.

Test Plan:
- Four digits in scan order (dig_en=0001 seg=30, 0010 seg=6D, 0100 seg=79, 1000 seg=33), each held for 3 sampled cycles, frame_ready=1 -> bcd_out=16'h4321, digit_err=0, frame_valid=1 for exactly 1 cycle, rising 1 cycle after the 4th commit.
- Digit 0 shows seg=30 for 2 samples, then seg=6D for 3 samples -> slot 0 commits 2 only; no commit of 1.
- Slot 2 shows illegal seg=7'h01 for 3 samples, others legal, blank (00) on slot 3 -> digit_err=4'b0100, bcd_out[11:8]=F, bcd_out[15:12]=F with err bit 3 clear.
- frame_ready=0 for 20 cycles while a second frame 9,8,7,6 is scanned -> bcd_out held at the first frame. Then frame_ready=1 -> frame_valid drops, then re-asserts with 16'h6789 two cycles after acceptance.
- Abnormal conditions:
  - dig_en=0011 held for 10 samples -> no commit.
  - rst_n pulsed low after 3 slots are captured -> frame_valid stays 0 and a full new frame is required.
- SEG_ACTIVE_LOW_EN defined, dig_en=~0001, seg_in=~7E for 3 samples (all digits likewise) -> bcd_out=16'h0000, digit_err=0.

Source files
------------

// File: rtl/seg_scan_reader.sv
// seg_scan_reader
//   Reads back a scanned, multiplexed 7-segment display bus and recovers the
//   BCD digit shown at each position. Each position's pattern is debounced
//   over STABLE_CNT consecutive identical samples before it is committed to a
//   shadow slot. Once all NUM_DIGITS slots are captured, the frame is copied to
//   the outputs and offered with a valid/ready handshake.
//
//   Build option: define SEG_ACTIVE_LOW_EN for common-anode displays. seg_in
//   and dig_en are then inverted on entry, so a blank digit is all lines high.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   sample_en    inputs are evaluated only on edges where this is high
//   seg_in[6:0]  segment lines abcdefg (bit 6 = a)
//   dig_en       one-hot digit select, bit i = position i
//   bcd_out      frame digits, digit i at [4i+3:4i]; 4'hF = blank/illegal
//   digit_err    per digit: the committed pattern was not a legal glyph
//   frame_valid  frame available; bcd_out/digit_err are stable while high
//   frame_ready  consumer accepts the frame
module seg_scan_reader #(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_en,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  input  logic                    frame_ready
);

  localparam int          CW     = 4;
  localparam int          SW     = NUM_DIGITS + 7;
  localparam logic [CW-1:0] STABLE = CW'(STABLE_CNT);

  typedef enum logic {COLLECT, HOLD} state_e;

  logic [6:0]            seg_w;
  logic [NUM_DIGITS-1:0] dig_w;

`ifdef SEG_ACTIVE_LOW_EN
  assign seg_w = ~seg_in;
  assign dig_w = ~dig_en;
`else
  assign seg_w = seg_in;
  assign dig_w = dig_en;
`endif

  state_e                  state_q, state_d;
  logic [SW-1:0]           prev_q, prev_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   captured_q, captured_d;
  logic [4*NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
  logic [NUM_DIGITS-1:0]   shadow_err_q, shadow_err_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    valid_q, valid_d;

  logic                    onehot;
  logic [SW-1:0]           sample;
  logic [NUM_DIGITS-1:0]   commit_mask;
  logic [4:0]              dec;

  // Returns {err, bcd}. Blank reads as F without error.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h7E:   r = {1'b0, 4'd0};
      7'h30:   r = {1'b0, 4'd1};
      7'h6D:   r = {1'b0, 4'd2};
      7'h79:   r = {1'b0, 4'd3};
      7'h33:   r = {1'b0, 4'd4};
      7'h5B:   r = {1'b0, 4'd5};
      7'h5F:   r = {1'b0, 4'd6};
      7'h70:   r = {1'b0, 4'd7};
      7'h7F:   r = {1'b0, 4'd8};
      7'h7B:   r = {1'b0, 4'd9};
      7'h00:   r = {1'b0, 4'hF};
      default: r = {1'b1, 4'hF};
    endcase
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    cnt_d        = cnt_q;
    captured_d   = captured_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_err_d = shadow_err_q;
    bcd_d        = bcd_q;
    err_d        = err_q;
    valid_d      = valid_q;
    commit_mask  = '0;
    onehot       = $onehot(dig_w);
    sample       = {dig_w, seg_w};
    dec          = decode(seg_w);

    if (sample_en) begin
      prev_d = sample;
      if (!onehot) begin
        cnt_d = '0;
      end else if (sample == prev_q) begin
        cnt_d = (cnt_q >= STABLE) ? STABLE : cnt_q + 4'd1;
      end else begin
        cnt_d = 4'd1;
      end
      // Commit only on the edge the counter reaches STABLE, not while saturated.
      if (onehot && (cnt_q != STABLE) && (cnt_d == STABLE)) begin
        commit_mask = dig_w;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (dig_w[i]) begin
            shadow_bcd_d[4*i +: 4] = dec[3:0];
            shadow_err_d[i]        = dec[4];
          end
        end
      end
    end

    case (state_q)
      COLLECT: begin
        if (&captured_q) begin
          bcd_d      = shadow_bcd_q;
          err_d      = shadow_err_q;
          valid_d    = 1'b1;
          // Mask is cleared, but a commit on this same edge still counts.
          captured_d = commit_mask;
          state_d    = HOLD;
        end else begin
          captured_d = captured_q | commit_mask;
        end
      end
      HOLD: begin
        captured_d = captured_q | commit_mask;
        if (valid_q && frame_ready) begin
          valid_d = 1'b0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= COLLECT;
      prev_q       <= '0;
      cnt_q        <= '0;
      captured_q   <= '0;
      shadow_bcd_q <= '0;
      shadow_err_q <= '0;
      bcd_q        <= '0;
      err_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      captured_q   <= captured_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_err_q <= shadow_err_d;
      bcd_q        <= bcd_d;
      err_q        <= err_d;
      valid_q      <= valid_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign digit_err   = err_q;
  assign frame_valid = valid_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// tb_seg_scan_reader
//   Directed bench for seg_scan_reader (NUM_DIGITS=4, STABLE_CNT=3).
//   Inputs are driven 1 ns after each rising edge and outputs sampled there.
//   With SEG_ACTIVE_LOW_EN defined the bench drives inverted lines; expected
//   values are unchanged.
module tb_seg_scan_reader;

  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_en = 1'b1;
  logic [6:0]    seg_in;
  logic [ND-1:0] dig_en;
  logic [4*ND-1:0] bcd_out;
  logic [ND-1:0] digit_err;
  logic          frame_valid;
  logic          frame_ready = 1'b1;

  int n_vec = 0;
  int n_bad = 0;

  seg_scan_reader #(.NUM_DIGITS(ND), .STABLE_CNT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_en   (sample_en),
    .seg_in      (seg_in),
    .dig_en      (dig_en),
    .bcd_out     (bcd_out),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [ND-1:0] d, input logic [6:0] s);
`ifdef SEG_ACTIVE_LOW_EN
    dig_en = ~d;
    seg_in = ~s;
`else
    dig_en = d;
    seg_in = s;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic show(input logic [ND-1:0] d, input logic [6:0] s, input int n);
    set_in(d, s);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic idle(input int n);
    show('0, 7'h00, n);
  endtask

  initial begin
    set_in('0, 7'h00);
    #12;
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_err", 32'(digit_err), 32'h0);
    check("rst_valid", 32'(frame_valid), 32'h0);
    rst_n = 1'b1;
    tick();

    // Frame 4321, consumer always ready.
    show(4'b0001, 7'h30, 3);
    show(4'b0010, 7'h6D, 3);
    show(4'b0100, 7'h79, 3);
    show(4'b1000, 7'h33, 3);
    check("f1_valid_at_commit", 32'(frame_valid), 32'h0);
    idle(1);
    check("f1_valid", 32'(frame_valid), 32'h1);
    check("f1_bcd", 32'(bcd_out), 32'h4321);
    check("f1_err", 32'(digit_err), 32'h0);
    idle(1);
    check("f1_valid_drop", 32'(frame_valid), 32'h0);

    // Glitch on slot 0, illegal glyph on slot 2, blank on slot 3.
    show(4'b0001, 7'h30, 2);
    show(4'b0001, 7'h6D, 3);
    show(4'b0010, 7'h7E, 3);
    show(4'b0100, 7'h01, 3);
    show(4'b1000, 7'h00, 3);
    idle(1);
    check("f2_valid", 32'(frame_valid), 32'h1);
    check("f2_bcd", 32'(bcd_out), 32'hFF02);
    check("f2_err", 32'(digit_err), 32'h4);
    idle(1);
    check("f2_valid_drop", 32'(frame_valid), 32'h0);

    // Back-pressure: second frame collected while the first is held.
    frame_ready = 1'b0;
    show(4'b0001, 7'h30, 3);
    show(4'b0010, 7'h6D, 3);
    show(4'b0100, 7'h79, 3);
    show(4'b1000, 7'h33, 3);
    idle(1);
    check("f3_valid", 32'(frame_valid), 32'h1);
    check("f3_bcd", 32'(bcd_out), 32'h4321);
    show(4'b0001, 7'h7B, 3);
    check("hold_bcd_a", 32'(bcd_out), 32'h4321);
    show(4'b0010, 7'h7F, 3);
    show(4'b0100, 7'h70, 3);
    check("hold_valid_a", 32'(frame_valid), 32'h1);
    show(4'b1000, 7'h5F, 3);
    idle(7);
    check("hold_valid_b", 32'(frame_valid), 32'h1);
    check("hold_bcd_b", 32'(bcd_out), 32'h4321);
    frame_ready = 1'b1;
    tick();
    check("accept_valid_drop", 32'(frame_valid), 32'h0);
    check("accept_bcd_held", 32'(bcd_out), 32'h4321);
    tick();
    check("f4_valid", 32'(frame_valid), 32'h1);
    check("f4_bcd", 32'(bcd_out), 32'h6789);
    tick();
    check("f4_valid_drop", 32'(frame_valid), 32'h0);

    // Multi-hot select never commits; a 2-sample glyph never commits.
    show(4'b0010, 7'h7E, 3);
    show(4'b0100, 7'h30, 3);
    show(4'b1000, 7'h6D, 3);
    show(4'b0011, 7'h30, 10);
    idle(3);
    check("multihot_no_frame", 32'(frame_valid), 32'h0);
    show(4'b0001, 7'h30, 2);
    idle(3);
    check("short_no_frame", 32'(frame_valid), 32'h0);
    show(4'b0001, 7'h79, 3);
    idle(1);
    check("f5_valid", 32'(frame_valid), 32'h1);
    check("f5_bcd", 32'(bcd_out), 32'h2103);
    idle(1);

    // sample_en low freezes debouncing.
    sample_en = 1'b0;
    show(4'b0001, 7'h5B, 5);
    sample_en = 1'b1;
    show(4'b0010, 7'h5F, 3);
    show(4'b0100, 7'h70, 3);
    show(4'b1000, 7'h33, 3);
    idle(3);
    check("sample_en_frozen", 32'(frame_valid), 32'h0);

    // Reset mid-frame discards partial captures (slots 1..3 are captured here).
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(frame_valid), 32'h0);
    check("midrst_bcd", 32'(bcd_out), 32'h0);
    tick();
    rst_n = 1'b1;
    show(4'b0001, 7'h5B, 3);
    idle(3);
    check("post_rst_no_frame", 32'(frame_valid), 32'h0);
    show(4'b0010, 7'h5F, 3);
    show(4'b0100, 7'h70, 3);
    show(4'b1000, 7'h33, 3);
    idle(1);
    check("f6_valid", 32'(frame_valid), 32'h1);
    check("f6_bcd", 32'(bcd_out), 32'h4765);
    check("f6_err", 32'(digit_err), 32'h0);
    idle(1);

    // All zeros frame.
    show(4'b0001, 7'h7E, 3);
    show(4'b0010, 7'h7E, 3);
    show(4'b0100, 7'h7E, 3);
    show(4'b1000, 7'h7E, 3);
    idle(1);
    check("f7_valid", 32'(frame_valid), 32'h1);
    check("f7_bcd", 32'(bcd_out), 32'h0000);
    check("f7_err", 32'(digit_err), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
